// File: rtl/mips_defs.sv
// Shared MIPS definitions: widths, opcodes and the fetch-buffer entry layout.
`timescale 1ns/1ps
package mips_defs;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[31:26];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH entries of {pc4, instr} with push/pop/flush and occupancy.
`timescale 1ns/1ps
module fetch_fifo
    import mips_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  fetch_entry_t           i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != DEPTH_C) || w_pop);

    // Flush only rewinds pointers; stale data stays behind the cleared valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '{pc4: '0, instr: NOP};
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, IF/ID buffer.
// Define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_flush_cnt outputs.
`timescale 1ns/1ps
module if_fetch_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               ifid_valid,
    input  logic               ifid_ready,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [5:0]         ifid_opcode,
    output logic [ADDR_W-1:0]  ifid_pc4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC0 = RESET_PC & ~32'd3;

    logic              r_started;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_drop;

    logic [CW-1:0]     w_count;
    logic [CW:0]       w_used;
    logic              w_empty;
    logic              w_hs;
    logic              w_rsp;
    logic              w_dropping;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_redir_pc;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_data;

    assign w_redir_pc = redirect_pc & ~32'd3;
    assign w_pop      = ifid_valid && ifid_ready;

    // A pop this cycle frees a slot, so the credit check sees it already.
    assign w_used = {1'b0, r_inflight} + {1'b0, w_count} - (CW+1)'(w_pop);
    assign imem_req_valid = r_started && !redirect_valid && (w_used < DEPTH_C);
    assign imem_req_addr  = r_pc;
    assign w_hs           = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding belong to a pre-reset request.
    assign w_rsp       = imem_rsp_valid && (r_inflight != '0);
    assign w_dropping  = (r_drop != '0);
    assign w_push      = w_rsp && !w_dropping && !redirect_valid;
    assign w_push_data = '{pc4: r_rsp_pc + 32'd4, instr: imem_rsp_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started  <= 1'b0;
            r_pc       <= PC0;
            r_rsp_pc   <= PC0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_started  <= 1'b1;
            r_inflight <= r_inflight + CW'(w_hs) - CW'(w_rsp);
            if (redirect_valid) begin
                r_pc     <= w_redir_pc;
                r_rsp_pc <= w_redir_pc;
                r_drop   <= r_inflight - CW'(w_rsp);
            end else begin
                if (w_hs) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_rsp && w_dropping) begin
                    r_drop <= r_drop - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign ifid_valid  = !w_empty;
    assign ifid_instr  = w_head.instr;
    assign ifid_opcode = opcode_of(w_head.instr);
    assign ifid_pc4    = w_head.pc4;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_discard;

    assign w_discard = w_rsp && (w_dropping || redirect_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_fetch_cnt <= r_fetch_cnt + 32'(w_pop);
            r_flush_cnt <= r_flush_cnt + 32'(redirect_valid) + 32'(w_discard);
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed stall/redirect/backpressure/reset.
`timescale 1ns/1ps
module tb_if_fetch_stage;
    import mips_defs::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [31:0] ifid_instr;
    logic [5:0]  ifid_opcode;
    logic [31:0] ifid_pc4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr = 32'h0;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_pop  = 0;
    int          mem_lat = 1;
    logic        d_v = 1'b0;
    logic [31:0] d_a = 32'h0;

    if_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_ready     (ifid_ready),
        .ifid_instr     (ifid_instr),
        .ifid_opcode    (ifid_opcode),
        .ifid_pc4       (ifid_pc4)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [5:0] op;
        case (a[4:2])
            3'd0:    op = OP_RTYPE;
            3'd1:    op = OP_LW;
            3'd2:    op = OP_SW;
            3'd3:    op = OP_BEQ;
            3'd4:    op = OP_BNE;
            3'd5:    op = OP_ADDI;
            3'd6:    op = OP_J;
            default: op = OP_JAL;
        endcase
        return {op, a[25:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
        check("rst_ifid_instr", ifid_instr, 32'h0);
        check("rst_ifid_opcode", {26'b0, ifid_opcode}, 32'h0);
        check("rst_ifid_pc4", ifid_pc4, 32'h0);
    endtask

    // Instruction memory: samples handshake mid-cycle, answers after 1 or 2 edges.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    end

    always begin
        logic        h;
        logic [31:0] ha;
        @(negedge clk);
        h  = imem_req_valid && imem_req_ready;
        ha = imem_req_addr;
        @(posedge clk);
        #1;
        if (mem_lat == 2) begin
            imem_rsp_valid = d_v;
            imem_rsp_data  = word(d_a);
            d_v = h;
            d_a = ha;
        end else begin
            imem_rsp_valid = h;
            imem_rsp_data  = word(ha);
        end
    end

    // Monitor: checks the IF/ID head and request stream against the model queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            exp_addr = 32'h0;
        end else begin
            if (ifid_valid) begin
                if (exp_q.size() == 0) begin
                    check("ifid_unexpected_pc4", ifid_pc4, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q[0];
                    check("ifid_pc4", ifid_pc4, e.pc4);
                    check("ifid_instr", ifid_instr, e.instr);
                    check("ifid_opcode", {26'b0, ifid_opcode},
                          {26'b0, e.instr[31:26]});
                    if (ifid_ready) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end
            if (imem_req_valid) begin
                check("req_addr", imem_req_addr, exp_addr);
                check("req_during_redirect", {31'b0, redirect_valid}, 32'h0);
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_addr = redirect_pc & ~32'd3;
            end else if (imem_req_valid && imem_req_ready) begin
                exp_q.push_back('{pc4: exp_addr + 32'd4, instr: word(exp_addr)});
                exp_addr = exp_addr + 32'd4;
                check("credit_limit", {31'b0, exp_q.size() <= DEPTH}, 32'h1);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ifid_ready     = 1'b0;
        #1;
        check_reset_outputs();
        step(2);
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b1;
        step(15);

        ifid_ready = 1'b0;
        step(5);
        check("stall_credit_stop", {31'b0, imem_req_valid}, 32'h0);
        ifid_ready = 1'b1;
        step(5);

        mem_lat = 2;
        step(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step(1);
        redirect_valid = 1'b0;
        check("flush_valid", {31'b0, ifid_valid}, 32'h0);
        step(10);

        imem_req_ready = 1'b0;
        step(3);
        imem_req_ready = 1'b1;
        step(6);

        ifid_ready = 1'b0;
        step(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step(1);
        redirect_valid = 1'b0;
        check("flush_while_stalled", {31'b0, ifid_valid}, 32'h0);
        step(1);
        ifid_ready = 1'b1;
        step(8);

        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(10);

        check("enough_pops", {31'b0, n_pop >= 20}, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
